bcd_time_counter: RTL and testbench

Timekeeping core of the wall clock: divides the 10 MHz board clock to a 1 Hz tick and maintains 24-hour time as four BCD digits (h10, h1, m10, m1) plus seconds. Feeds the multiplexed 7-segment display stage directly; its digit outputs connect one-to-one to that stage's digit inputs. Two push-button inputs let the user pause the clock and set hours and minutes.

---
 rtl/bcd_time_counter.sv | 172 +++++++++++++++++
 tb/tb_bcd_time_counter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// Wall-clock timekeeping core: prescales the board clock to 1 Hz and keeps 24-hour BCD time.
// Two debounced buttons pause the clock and set hours/minutes.
module bcd_time_counter #(
  parameter int unsigned TICKS_PER_SEC = 10000000
) (
  input  logic       mhz10clock,
  input  logic       Reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] h10,
  output logic [3:0] h1,
  output logic [3:0] m10,
  output logic [3:0] m1,
  output logic [3:0] s10,
  output logic [3:0] s1,
  output logic       sec_tick,
  output logic       colon_on,
  output logic [1:0] set_mode
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PrescMax = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StSetHour = 2'b01,
    StSetMin  = 2'b10
  } state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [3:0]    h10_q, h1_q, m10_q, m1_q, s10_q, s1_q;
  logic          sec_tick_q, colon_q;
  logic          mode_s1_q, mode_s2_q, mode_prev_q;
  logic          inc_s1_q, inc_s2_q, inc_prev_q;

  logic       mode_pulse, inc_pulse;
  logic [3:0] s1_inc, s10_inc, m1_inc, m10_inc, h1_inc, h10_inc;
  logic       carry_s, carry_m;

  assign mode_pulse = mode_s2_q & ~mode_prev_q;
  assign inc_pulse  = inc_s2_q & ~inc_prev_q;

  // Per-digit BCD successors; carries tell the FSM which higher fields roll over.
  always_comb begin
    s1_inc  = s1_q + 4'd1;
    s10_inc = s10_q;
    carry_s = 1'b0;
    if (s1_q == 4'd9) begin
      s1_inc = 4'd0;
      if (s10_q == 4'd5) begin
        s10_inc = 4'd0;
        carry_s = 1'b1;
      end else begin
        s10_inc = s10_q + 4'd1;
      end
    end

    m1_inc  = m1_q + 4'd1;
    m10_inc = m10_q;
    carry_m = 1'b0;
    if (m1_q == 4'd9) begin
      m1_inc = 4'd0;
      if (m10_q == 4'd5) begin
        m10_inc = 4'd0;
        carry_m = 1'b1;
      end else begin
        m10_inc = m10_q + 4'd1;
      end
    end

    h1_inc  = h1_q + 4'd1;
    h10_inc = h10_q;
    if (h10_q == 4'd2 && h1_q == 4'd3) begin
      h1_inc  = 4'd0;
      h10_inc = 4'd0;
    end else if (h1_q == 4'd9) begin
      h1_inc  = 4'd0;
      h10_inc = h10_q + 4'd1;
    end
  end

  always_ff @(posedge mhz10clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StRun;
      presc_q     <= '0;
      h10_q       <= 4'd0;
      h1_q        <= 4'd0;
      m10_q       <= 4'd0;
      m1_q        <= 4'd0;
      s10_q       <= 4'd0;
      s1_q        <= 4'd0;
      sec_tick_q  <= 1'b0;
      colon_q     <= 1'b1;
      mode_s1_q   <= 1'b0;
      mode_s2_q   <= 1'b0;
      mode_prev_q <= 1'b0;
      inc_s1_q    <= 1'b0;
      inc_s2_q    <= 1'b0;
      inc_prev_q  <= 1'b0;
    end else begin
      mode_s1_q   <= mode_btn;
      mode_s2_q   <= mode_s1_q;
      mode_prev_q <= mode_s2_q;
      inc_s1_q    <= inc_btn;
      inc_s2_q    <= inc_s1_q;
      inc_prev_q  <= inc_s2_q;
      sec_tick_q  <= 1'b0;

      unique case (state_q)
        StRun: begin
          // A mode press beats a coincident terminal count: the tick is discarded.
          if (mode_pulse) begin
            state_q <= StSetHour;
            presc_q <= '0;
            s10_q   <= 4'd0;
            s1_q    <= 4'd0;
            colon_q <= 1'b1;
          end else if (presc_q == PrescMax) begin
            presc_q    <= '0;
            sec_tick_q <= 1'b1;
            s1_q       <= s1_inc;
            s10_q      <= s10_inc;
            colon_q    <= ~s1_inc[0];
            if (carry_s) begin
              m1_q  <= m1_inc;
              m10_q <= m10_inc;
              if (carry_m) begin
                h1_q  <= h1_inc;
                h10_q <= h10_inc;
              end
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        StSetHour: begin
          presc_q <= '0;
          colon_q <= 1'b1;
          if (mode_pulse) begin
            state_q <= StSetMin;
          end else if (inc_pulse) begin
            h1_q  <= h1_inc;
            h10_q <= h10_inc;
          end
        end
        StSetMin: begin
          presc_q <= '0;
          colon_q <= 1'b1;
          if (mode_pulse) begin
            state_q <= StRun;
          end else if (inc_pulse) begin
            m1_q  <= m1_inc;
            m10_q <= m10_inc;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign h10      = h10_q;
  assign h1       = h1_q;
  assign m10      = m10_q;
  assign m1       = m1_q;
  assign s10      = s10_q;
  assign s1       = s1_q;
  assign sec_tick = sec_tick_q;
  assign colon_on = colon_q;
  assign set_mode = state_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter with TICKS_PER_SEC=4; expectations come from a
// behavioural time model and are queued before each stimulus step, popped at each compare.
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [3:0] h10, h1, m10, m1, s10, s1;
  logic       sec_tick, colon_on;
  logic [1:0] set_mode;

  bcd_time_counter #(.TICKS_PER_SEC(4)) dut (
    .mhz10clock(clk),
    .Reset     (rst_n),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .h10       (h10),
    .h1        (h1),
    .m10       (m10),
    .m1        (m1),
    .s10       (s10),
    .s1        (s1),
    .sec_tick  (sec_tick),
    .colon_on  (colon_on),
    .set_mode  (set_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [23:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   mh = 0, mm = 0, ms = 0, st = 0;
  int   ticks_seen = 0;

  function automatic logic [23:0] pack_time(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] obs_time();
    return {h10, h1, m10, m1, s10, s1};
  endfunction

  task automatic expect_val(input string tag, input logic [23:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [23:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      $error("FAIL scoreboard_empty: got %0h required an entry", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.exp) n_pass++;
    else $error("FAIL %s: got %0h required %0h", e.tag, obs, e.exp);
  endtask

  task automatic model_tick();
    ms++;
    if (ms == 60) begin
      ms = 0;
      mm++;
      if (mm == 60) begin
        mm = 0;
        mh = (mh + 1) % 24;
      end
    end
  endtask

  // Counts negedges until sec_tick is seen; a missing tick yields an oversize gap.
  task automatic wait_tick(output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!sec_tick && gap < 20);
    if (sec_tick) model_tick();
  endtask

  task automatic check_all(input string tag);
    expect_val({tag, "_time"}, pack_time(mh, mm, ms));
    check(obs_time());
    expect_val({tag, "_mode"}, 24'(st));
    check(24'(set_mode));
    expect_val({tag, "_colon"}, 24'((st != 0) || (ms % 2 == 0)));
    check(24'(colon_on));
  endtask

  task automatic press(input bit is_mode);
    if (is_mode) mode_btn = 1'b1;
    else inc_btn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (sec_tick) ticks_seen++;
    end
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (sec_tick) ticks_seen++;
    end
  endtask

  task automatic do_mode();
    press(1'b1);
    if (st == 0) begin
      st = 1;
      ms = 0;
    end else if (st == 1) begin
      st = 2;
    end else begin
      st = 0;
    end
  endtask

  task automatic do_inc();
    press(1'b0);
    if (st == 1) mh = (mh + 1) % 24;
    else if (st == 2) mm = (mm + 1) % 60;
  endtask

  // SET_MIN -> RUN, then measure the distance to the first tick.
  task automatic return_to_run(input string tag);
    int gap;
    mode_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mode_btn = 1'b0;
    @(negedge clk);
    st = 0;
    check_all(tag);
    expect_val({tag, "_first_tick"}, 24'd4);
    wait_tick(gap);
    check(24'(gap));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int gap;
    int t0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all("reset");
    expect_val("reset_tick", 24'd0);
    check(24'(sec_tick));
    rst_n = 1'b1;

    // Free run: 240 ticks spaced 4 cycles apart, colon tracks s1 parity
    for (int i = 0; i < 240; i++) begin
      expect_val("tick_gap", 24'd4);
      wait_tick(gap);
      check(24'(gap));
      expect_val("run_colon", 24'(ms % 2 == 0));
      check(24'(colon_on));
    end
    expect_val("free_run_0400", 24'h000400);
    check(obs_time());
    check_all("free_run");

    // Set-hour wrap: 25 increments from 00 gives 01, no ticks while setting
    t0 = ticks_seen;
    do_mode();
    for (int i = 0; i < 25; i++) do_inc();
    check_all("set_hour");
    expect_val("set_hour_no_tick", 24'd0);
    check(24'(ticks_seen - t0));

    // Set-minute wrap: 61 increments, no carry into hours
    do_mode();
    for (int i = 0; i < 61; i++) do_inc();
    check_all("set_min");
    expect_val("set_min_no_tick", 24'd0);
    check(24'(ticks_seen - t0));
    return_to_run("exit_set_min");

    // Rollover from 23:59 through 60 ticks
    do_mode();
    while (mh != 23) do_inc();
    do_mode();
    while (mm != 59) do_inc();
    return_to_run("to_2359");
    for (int i = 0; i < 58; i++) begin
      expect_val("roll_gap", 24'd4);
      wait_tick(gap);
      check(24'(gap));
    end
    check_all("pre_roll");
    expect_val("roll_gap_last", 24'd4);
    wait_tick(gap);
    check(24'(gap));
    expect_val("rollover_000000", 24'h000000);
    check(obs_time());
    expect_val("rollover_tick", 24'd1);
    check(24'(sec_tick));

    // inc held for 50 cycles counts once; mode+inc together only advances state
    do_mode();
    inc_btn = 1'b1;
    repeat (50) @(negedge clk);
    inc_btn = 1'b0;
    repeat (3) @(negedge clk);
    mh = (mh + 1) % 24;
    check_all("inc_held");
    mode_btn = 1'b1;
    inc_btn  = 1'b1;
    repeat (2) @(negedge clk);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    repeat (2) @(negedge clk);
    st = 2;
    check_all("mode_and_inc");
    return_to_run("exit_after_both");

    // Mode press landing on a terminal count discards the tick
    repeat (2) begin
      expect_val("pre_tc_gap", 24'd4);
      wait_tick(gap);
      check(24'(gap));
    end
    @(negedge clk);
    mode_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mode_btn = 1'b0;
    @(negedge clk);
    st = 1;
    ms = 0;
    check_all("mode_on_tc");
    expect_val("mode_on_tc_tick", 24'd0);
    check(24'(sec_tick));

    // Asynchronous reset from 13:27:42
    while (mh != 13) do_inc();
    do_mode();
    while (mm != 27) do_inc();
    return_to_run("to_1327");
    while (ms != 42) begin
      wait_tick(gap);
      if (gap >= 20) break;
    end
    expect_val("pre_reset_132742", 24'h132742);
    check(obs_time());
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    mh = 0;
    mm = 0;
    ms = 0;
    st = 0;
    check_all("async_reset");
    expect_val("async_reset_tick", 24'd0);
    check(24'(sec_tick));
    @(negedge clk);
    rst_n = 1'b1;
    expect_val("post_reset_gap", 24'd4);
    wait_tick(gap);
    check(24'(gap));
    check_all("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
